// File: rtl/song_autoplayer_pkg.sv
// Shared piano note codes, LED patterns and song ROM types for the autoplayer.
// The note codes match the keyboard decoder so playback looks like live key presses.
package song_autoplayer_pkg;

   localparam logic [3:0] NOTE_NONE = 4'd0;
   localparam logic [3:0] NOTE_C4   = 4'd1;
   localparam logic [3:0] NOTE_D    = 4'd2;
   localparam logic [3:0] NOTE_E    = 4'd3;
   localparam logic [3:0] NOTE_F    = 4'd4;
   localparam logic [3:0] NOTE_G    = 4'd5;

   localparam logic [7:0] LED_C4 = 8'b0000_0001;
   localparam logic [7:0] LED_D  = 8'b0000_0010;
   localparam logic [7:0] LED_E  = 8'b0000_0100;
   localparam logic [7:0] LED_F  = 8'b0000_1000;
   localparam logic [7:0] LED_G  = 8'b0001_0000;

   localparam int         SONG_LEN = 15;
   localparam logic [3:0] LAST_IDX = 4'(SONG_LEN - 1);

   typedef struct packed {
      logic [3:0] code;
      logic [2:0] dur;
   } song_entry_t;

   function automatic logic [7:0] led_of(input logic [3:0] code);
      logic [7:0] pattern;
      case (code)
         NOTE_C4: pattern = LED_C4;
         NOTE_D:  pattern = LED_D;
         NOTE_E:  pattern = LED_E;
         NOTE_F:  pattern = LED_F;
         NOTE_G:  pattern = LED_G;
         default: pattern = 8'b0000_0000;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/song_autoplayer_song_rom.sv
// Combinational song table: first phrase of Ode to Joy as {note code, duration in half-beats}.
// Swap this module to play a different tune.
module song_rom
   import song_autoplayer_pkg::*;
(
   input  logic [3:0]  idx,
   output song_entry_t entry
);

   // Index to {code, dur} lookup; out-of-range indices return a silent one-tick entry.
   always_comb begin
      entry = '{code: NOTE_NONE, dur: 3'd1};
      case (idx)
         4'd0:    entry = '{code: NOTE_E,  dur: 3'd2};
         4'd1:    entry = '{code: NOTE_E,  dur: 3'd2};
         4'd2:    entry = '{code: NOTE_F,  dur: 3'd2};
         4'd3:    entry = '{code: NOTE_G,  dur: 3'd2};
         4'd4:    entry = '{code: NOTE_G,  dur: 3'd2};
         4'd5:    entry = '{code: NOTE_F,  dur: 3'd2};
         4'd6:    entry = '{code: NOTE_E,  dur: 3'd2};
         4'd7:    entry = '{code: NOTE_D,  dur: 3'd2};
         4'd8:    entry = '{code: NOTE_C4, dur: 3'd2};
         4'd9:    entry = '{code: NOTE_C4, dur: 3'd2};
         4'd10:   entry = '{code: NOTE_D,  dur: 3'd2};
         4'd11:   entry = '{code: NOTE_E,  dur: 3'd2};
         4'd12:   entry = '{code: NOTE_E,  dur: 3'd3};
         4'd13:   entry = '{code: NOTE_D,  dur: 3'd1};
         4'd14:   entry = '{code: NOTE_D,  dur: 3'd4};
         default: entry = '{code: NOTE_NONE, dur: 3'd1};
      endcase
   end

endmodule

// File: rtl/song_autoplayer.sv
// Ode to Joy autoplayer: drives the shared note bus and LEDs like a player pressing keys,
// with a short silent gap closing every note so repeated notes read as separate presses.
module song_autoplayer
   import song_autoplayer_pkg::*;
#(
   parameter int TICK_DIV   = 12500000,
   parameter int GAP_CYCLES = 1250000,
   parameter int CNT_W      = 32
)(
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       START,
   input  logic       STOP,
   input  logic       LOOP,
   output logic [3:0] note,
   output logic [7:0] Led,
   output logic       PLAYING,
   output logic       DONE,
   output logic [3:0] idx
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SOUND = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   sound_last;
   logic [3:0]         next_idx;
   song_entry_t        cur_entry;
   song_entry_t        next_entry;

   song_rom u_rom_cur  (.idx(idx),      .entry(cur_entry));
   song_rom u_rom_next (.idx(next_idx), .entry(next_entry));

   assign next_idx = (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;

   // Last count of the sounded part of the current entry: dur*TICK_DIV - GAP_CYCLES - 1.
   always_comb begin
      sound_last = CNT_W'(cur_entry.dur) * CNT_W'(TICK_DIV) - CNT_W'(GAP_CYCLES) - CNT_W'(1);
   end

   // Playback FSM; outputs are updated on the same edge as the state they describe.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= IDLE;
         idx     <= 4'd0;
         cnt     <= '0;
         note    <= NOTE_NONE;
         Led     <= 8'b0000_0000;
         PLAYING <= 1'b0;
         DONE    <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (START && !STOP) begin
                  state   <= SOUND;
                  idx     <= 4'd0;
                  cnt     <= '0;
                  note    <= cur_entry.code;
                  Led     <= led_of(cur_entry.code);
                  PLAYING <= 1'b1;
               end else begin
                  state   <= IDLE;
                  idx     <= 4'd0;
                  cnt     <= '0;
                  note    <= NOTE_NONE;
                  Led     <= 8'b0000_0000;
                  PLAYING <= 1'b0;
               end
            end
            SOUND: begin
               if (STOP) begin
                  state   <= IDLE;
                  idx     <= 4'd0;
                  cnt     <= '0;
                  note    <= NOTE_NONE;
                  Led     <= 8'b0000_0000;
                  PLAYING <= 1'b0;
               end else if (cnt == sound_last) begin
                  state <= GAP;
                  cnt   <= '0;
                  note  <= NOTE_NONE;
                  Led   <= 8'b0000_0000;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            GAP: begin
               // STOP wins even over the final-note completion, so no DONE follows an abort.
               if (STOP) begin
                  state   <= IDLE;
                  idx     <= 4'd0;
                  cnt     <= '0;
                  note    <= NOTE_NONE;
                  Led     <= 8'b0000_0000;
                  PLAYING <= 1'b0;
               end else if (cnt == GAP_LAST) begin
                  cnt <= '0;
                  if ((idx != LAST_IDX) || LOOP) begin
                     state <= SOUND;
                     idx   <= next_idx;
                     note  <= next_entry.code;
                     Led   <= led_of(next_entry.code);
                  end else begin
                     state   <= IDLE;
                     idx     <= 4'd0;
                     PLAYING <= 1'b0;
                     DONE    <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               idx     <= 4'd0;
               cnt     <= '0;
               note    <= NOTE_NONE;
               Led     <= 8'b0000_0000;
               PLAYING <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_song_autoplayer.sv
// Scoreboard bench for song_autoplayer: a cycle-level model of the song (entry index and
// elapsed cycles) queues expected outputs, and a monitor compares them one step after each edge.
module tb_song_autoplayer;
   import song_autoplayer_pkg::*;

   localparam int TD  = 4;
   localparam int GAP = 1;

   localparam logic [3:0] SONG_CODE [15] = '{NOTE_E, NOTE_E, NOTE_F, NOTE_G, NOTE_G,
                                             NOTE_F, NOTE_E, NOTE_D, NOTE_C4, NOTE_C4,
                                             NOTE_D, NOTE_E, NOTE_E, NOTE_D, NOTE_D};
   localparam int SONG_TICKS [15] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3, 1, 4};

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       START = 1'b0;
   logic       STOP = 1'b0;
   logic       LOOP = 1'b0;
   logic [3:0] note;
   logic [7:0] Led;
   logic       PLAYING;
   logic       DONE;
   logic [3:0] idx;

   typedef struct packed {
      logic [3:0] note;
      logic [7:0] led;
      logic       playing;
      logic       done;
      logic [3:0] idx;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   bit   m_active = 1'b0;
   int   m_entry = 0;
   int   m_elapsed = 0;
   bit   m_done = 1'b0;

   song_autoplayer #(.TICK_DIV(TD), .GAP_CYCLES(GAP), .CNT_W(32)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .START(START), .STOP(STOP), .LOOP(LOOP),
      .note(note), .Led(Led), .PLAYING(PLAYING), .DONE(DONE), .idx(idx)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] exp_led(input logic [3:0] c);
      case (c)
         NOTE_C4: return 8'b0000_0001;
         NOTE_D:  return 8'b0000_0010;
         NOTE_E:  return 8'b0000_0100;
         NOTE_F:  return 8'b0000_1000;
         NOTE_G:  return 8'b0001_0000;
         default: return 8'b0000_0000;
      endcase
   endfunction

   // Advance the song model by one clock edge using the inputs seen at that edge.
   task automatic model_step();
      exp_t e;
      int   period;
      m_done = 1'b0;
      if (!m_active) begin
         if (START && !STOP) begin
            m_active = 1'b1; m_entry = 0; m_elapsed = 0;
         end
      end else if (STOP) begin
         m_active = 1'b0; m_entry = 0; m_elapsed = 0;
      end else begin
         m_elapsed++;
         if (m_elapsed == SONG_TICKS[m_entry] * TD) begin
            m_elapsed = 0;
            if (m_entry < 14) m_entry++;
            else if (LOOP) m_entry = 0;
            else begin
               m_active = 1'b0; m_entry = 0; m_done = 1'b1;
            end
         end
      end
      period    = SONG_TICKS[m_entry] * TD;
      e.note    = (m_active && (m_elapsed < period - GAP)) ? SONG_CODE[m_entry] : NOTE_NONE;
      e.led     = exp_led(e.note);
      e.playing = m_active;
      e.done    = m_done;
      e.idx     = 4'(m_entry);
      sb.push_back(e);
   endtask

   task automatic cyc(input bit s, input bit st, input bit lp);
      @(negedge CLK);
      START = s; STOP = st; LOOP = lp;
      @(posedge CLK);
      model_step();
   endtask

   task automatic check_reset_outputs(input string name);
      tests++;
      if (note !== NOTE_NONE || Led !== 8'd0 || PLAYING !== 1'b0 || DONE !== 1'b0 || idx !== 4'd0) begin
         fails++;
         $display("FAIL %s: note=%0d led=%b playing=%0d done=%0d idx=%0d, expected all zero/none",
                  name, note, Led, PLAYING, DONE, idx);
      end
   endtask

   task automatic bound_fail(input string name);
      tests++;
      fails++;
      $display("FAIL %s: wait bound expired, expected model condition reached", name);
   endtask

   // Monitor: compare the DUT against the oldest queued expectation one step after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (RESET_N && sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (note !== e.note || Led !== e.led || PLAYING !== e.playing ||
                DONE !== e.done || idx !== e.idx) begin
               fails++;
               $display("FAIL cycle@%0t: note=%0d led=%b playing=%0d done=%0d idx=%0d, expected note=%0d led=%b playing=%0d done=%0d idx=%0d",
                        $time, note, Led, PLAYING, DONE, idx,
                        e.note, e.led, e.playing, e.done, e.idx);
            end
         end
      end
   end

   initial begin
      int n;
      #12;
      check_reset_outputs("reset_state");
      @(negedge CLK);
      RESET_N = 1'b1;
      repeat (3) cyc(1'b0, 1'b0, 1'b0);

      // Full song without loop; START pulses at 3 and 50 must be ignored.
      cyc(1'b1, 1'b0, 1'b0);
      for (int i = 1; i < 140; i++) cyc((i == 3) || (i == 50), 1'b0, 1'b0);

      // Two passes with LOOP held, then abort.
      cyc(1'b1, 1'b0, 1'b1);
      for (int i = 1; i < 270; i++) cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b1);

      // STOP during idx 2 SOUND, then restart.
      cyc(1'b1, 1'b0, 1'b0);
      repeat (19) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      repeat (10) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);

      // START and STOP together in IDLE.
      repeat (3) cyc(1'b1, 1'b1, 1'b0);

      // STOP on the final GAP cycle must suppress DONE.
      cyc(1'b1, 1'b0, 1'b0);
      n = 0;
      while (!(m_entry == 14 && m_elapsed == SONG_TICKS[14] * TD - 1) && n < 300) begin
         cyc(1'b0, 1'b0, 1'b0);
         n++;
      end
      if (n >= 300) bound_fail("reach_final_gap");
      cyc(1'b0, 1'b1, 1'b0);
      repeat (5) cyc(1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of idx 5 SOUND.
      cyc(1'b1, 1'b0, 1'b0);
      n = 0;
      while (!(m_entry == 5 && m_elapsed == 2) && n < 300) begin
         cyc(1'b0, 1'b0, 1'b0);
         n++;
      end
      if (n >= 300) bound_fail("reach_idx5");
      @(negedge CLK);
      #2;
      RESET_N = 1'b0;
      #1;
      check_reset_outputs("async_reset_midplay");
      m_active = 1'b0; m_entry = 0; m_elapsed = 0; m_done = 1'b0;
      repeat (3) @(negedge CLK);
      check_reset_outputs("reset_held");
      RESET_N = 1'b1;
      repeat (10) cyc(1'b0, 1'b0, 1'b0);

      // Random mix of START, STOP and LOOP.
      repeat (3000) cyc($urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)));

      n = 0;
      while (sb.size() > 0 && n < 5) begin
         @(posedge CLK);
         n++;
      end
      #2;
      if (sb.size() > 0) bound_fail("scoreboard_drain");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
